// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular exponentiation core and its Montgomery multiplier.
package rsa_pkg;

    localparam int unsigned W = 256;

    typedef logic [W-1:0] word_t;

    // Exponentiation sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } exp_state_t;

    // Montgomery multiplier states
    typedef enum logic [1:0] {
        MmIdle,
        MmRun,
        MmFix
    } mm_state_t;

endpackage

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = a * b * 2^-W mod n.
// One operand bit per cycle for W cycles, then one conditional-subtract cycle.
module montgomery_mult
    import rsa_pkg::*;
#(
    parameter int unsigned W = rsa_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] n_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         done_o
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    mm_state_t       state_q, state_d;
    // acc stays below 2n, so W+2 bits hold acc + b + n without overflow
    logic [W+1:0]    acc_q, acc_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    n_q, n_d;
    logic [CntW-1:0] i_q, i_d;

    logic [W+1:0]    sum;
    logic [W+1:0]    sum_red;
    logic [W-1:0]    diff;
    logic            acc_ge_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MmIdle;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            i_q     <= i_d;
        end
    end

    // One reduction step per cycle, a is consumed LSB first by shifting
    always_comb begin
        sum      = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
        sum_red  = sum + (sum[0] ? {2'b00, n_q} : '0);
        acc_ge_n = (acc_q >= {2'b00, n_q});
        // true difference is below 2^W whenever it is selected
        diff     = acc_q[W-1:0] - n_q;

        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        i_d     = i_q;

        case (state_q)
            MmIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    n_d     = n_i;
                    acc_d   = '0;
                    i_d     = '0;
                    state_d = MmRun;
                end
            end
            MmRun: begin
                acc_d = sum_red >> 1;
                a_d   = a_q >> 1;
                i_d   = i_q + CntW'(1);
                if (i_q == CntW'(W - 1)) begin
                    state_d = MmFix;
                end
            end
            MmFix: begin
                state_d = MmIdle;
            end
            default: begin
                state_d = MmIdle;
            end
        endcase
    end

    // Result is valid only during the correction cycle
    always_comb begin
        done_o   = (state_q == MmFix);
        result_o = acc_ge_n ? diff : acc_q[W-1:0];
    end

endmodule

// File: rtl/rsa_exp_core.sv
// Right-to-left square-and-multiply exponentiation: m = y^d mod n.
// t holds y^(2^k) in Montgomery form; m_acc stays in the normal domain because
// Mont(m_acc, t) = m_acc * y^(2^k) mod n.
module rsa_exp_core
    import rsa_pkg::*;
#(
    parameter int unsigned W = rsa_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] n_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] t_mont_i,
    output logic [W-1:0] m_o,
    output logic         busy_o,
    output logic         finish_o
);

    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned KW   = IdxW + 1;

    exp_state_t    state_q, state_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  macc_q, macc_d;
    logic [W-1:0]  m_q, m_d;
    logic [KW-1:0] k_q, k_d;

    logic          mm_start;
    logic [W-1:0]  res_a, res_b;
    logic          done_a, done_b;
    logic          d_bit;

    // Multiply path: m_acc * t
    montgomery_mult #(
        .W (W)
    ) u_mult_a (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mm_start),
        .n_i      (n_q),
        .a_i      (macc_q),
        .b_i      (t_q),
        .result_o (res_a),
        .done_o   (done_a)
    );

    // Square path: t * t
    montgomery_mult #(
        .W (W)
    ) u_mult_b (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mm_start),
        .n_i      (n_q),
        .a_i      (t_q),
        .b_i      (t_q),
        .result_o (res_b),
        .done_o   (done_b)
    );

    // Sequencer and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            d_q     <= '0;
            t_q     <= '0;
            macc_q  <= '0;
            m_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            t_q     <= t_d;
            macc_q  <= macc_d;
            m_q     <= m_d;
            k_q     <= k_d;
        end
    end

    // Next-state: one exponent bit per multiplier round
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        t_d     = t_q;
        macc_d  = macc_q;
        m_d     = m_q;
        k_d     = k_q;
        d_bit   = d_q[k_q[IdxW-1:0]];

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    n_d     = n_i;
                    d_d     = d_i;
                    t_d     = t_mont_i;
                    macc_d  = W'(1);
                    k_d     = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // both instances start together and have fixed latency
                if (done_a && done_b) begin
                    t_d = res_b;
                    if (d_bit) begin
                        macc_d = res_a;
                    end
                    k_d = k_q + KW'(1);
                    if (k_q == KW'(W - 1)) begin
                        // load m here so it is already valid during the finish cycle
                        m_d     = d_bit ? res_a : macc_q;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        mm_start = (state_q == StIssue);
        busy_o   = (state_q == StIssue) || (state_q == StWait);
        finish_o = (state_q == StDone);
        m_o      = m_q;
    end

endmodule

// File: tb/tb_rsa_exp_core.sv
// Scoreboard bench for rsa_exp_core at a reduced width so full runs fit the cycle budget.
module tb_rsa_exp_core;

    localparam int unsigned TW  = 16;
    localparam int unsigned LAT = (TW + 2) * TW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] n;
    logic [TW-1:0] d;
    logic [TW-1:0] t_mont;
    logic [TW-1:0] m;
    logic          busy;
    logic          finish;

    rsa_exp_core #(
        .W (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .n_i      (n),
        .d_i      (d),
        .t_mont_i (t_mont),
        .m_o      (m),
        .busy_o   (busy),
        .finish_o (finish)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] m;
        int unsigned   acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   busy_gaps = 0;
    logic fin_prev  = 1'b0;

    // Plain modular exponentiation over 64-bit integers
    function automatic longint unsigned modexp(longint unsigned y, longint unsigned e,
                                               longint unsigned nn);
        longint unsigned r = 1 % nn;
        longint unsigned b = y % nn;
        for (int i = 0; i < TW; i++) begin
            if (((e >> i) & 1) == 1) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r;
    endfunction

    function automatic longint unsigned to_mont(longint unsigned y, longint unsigned nn);
        return (y << TW) % nn;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every finish against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb.size() > 0 && !finish && cyc > sb[0].acc_cyc && busy !== 1'b1)
                busy_gaps++;
            if (finish === 1'b1) begin
                check("finish_width", 64'(fin_prev), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish: got finish=1 expected none at cycle %0d",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("m", 64'(m), 64'(e.m));
                    check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                    check("busy_held", 64'(busy_gaps), 64'd0);
                    busy_gaps = 0;
                end
            end
            fin_prev = finish;
        end
    end

    // Issue one request and record its expected result
    task automatic issue(longint unsigned nn, longint unsigned dd, longint unsigned yy);
        exp_t e;
        @(posedge clk);
        #1;
        n      = TW'(nn);
        d      = TW'(dd);
        t_mont = TW'(to_mont(yy, nn));
        start  = 1'b1;
        e.m       = TW'(modexp(yy, dd, nn));
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        n      = TW'($urandom);
        d      = TW'($urandom);
        t_mont = TW'($urandom);
    endtask

    // Junk start pulse that must be ignored
    task automatic poke_start();
        #1;
        n      = TW'($urandom);
        d      = TW'($urandom);
        t_mont = TW'($urandom);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_finish();
        bit seen = 1'b0;
        for (int i = 0; i < int'(LAT) + 20 && !seen; i++) begin
            @(negedge clk);
            if (finish === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL finish_timeout: got no finish expected one within %0d cycles",
                     LAT + 20);
        end
    endtask

    initial begin
        longint unsigned rn, ry, rd;
        logic [TW-1:0]   held;

        rst    = 1'b1;
        start  = 1'b0;
        n      = '0;
        d      = '0;
        t_mont = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m", 64'(m), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_finish", 64'(finish), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Textbook RSA pair and the exponent edge cases
        issue(3233, 17, 65);
        wait_finish();
        issue(3233, 2753, 2790);
        wait_finish();
        issue(3233, 0, 65);
        wait_finish();
        issue(3233, 1, 1234);
        wait_finish();
        issue(65535, 16'hFFFF, 65534);
        wait_finish();

        // Starts during a run and during the finish cycle are dropped
        issue(3233, 17, 65);
        repeat (98) @(posedge clk);
        poke_start();
        repeat (100) @(posedge clk);
        poke_start();
        wait_finish();
        held = TW'(modexp(65, 17, 3233));
        poke_start();
        repeat (2 * LAT) @(posedge clk);
        #1;
        check("m_held", 64'(m), 64'(held));
        check("idle_after_ignored", 64'(busy), 64'd0);

        // Reset in the middle of a run discards it
        issue(3233, 2753, 2790);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_m", 64'(m), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_finish", 64'(finish), 64'd0);
        sb.delete();
        busy_gaps = 0;
        @(negedge clk);
        rst = 1'b0;
        issue(3233, 17, 65);
        wait_finish();

        // Random odd moduli, bases and exponents
        for (int v = 0; v < 60; v++) begin
            rn = longint'($urandom_range(3, 65535)) | 1;
            ry = longint'($urandom) % rn;
            rd = longint'($urandom) & 64'hFFFF;
            issue(rn, rd, ry);
            wait_finish();
        end

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL outstanding: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
